// File: rtl/booth_mul_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// recoded digit values and the iteration-count helper.
package booth_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_P1   = 3'd1,
    DIG_P2   = 3'd2,
    DIG_M1   = 3'd3,
    DIG_M2   = 3'd4
  } digit_e;

  // Operands are extended by two bits, so (WIDTH+2)/2 digit pairs cover them.
  function automatic int step_count(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: triplet -> digit -> partial-product addend, with
// negation expressed as ones-complement plus a carry-in.
module booth_r4_recode
  import booth_mul_pkg::*;
#(
  parameter int EW = 34
) (
  input  logic [2:0]    i_triplet,
  input  logic [EW-1:0] i_y_ext,
  output logic [EW-1:0] o_addend,
  output logic          o_cin
);

  digit_e w_digit;

  always_comb begin
    case (i_triplet)
      3'b001, 3'b010: w_digit = DIG_P1;
      3'b011:         w_digit = DIG_P2;
      3'b100:         w_digit = DIG_M2;
      3'b101, 3'b110: w_digit = DIG_M1;
      default:        w_digit = DIG_ZERO;
    endcase
  end

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; a missing
    // assignment on any branch would infer a latch.
    o_addend = '0;
    o_cin    = 1'b0;
    case (w_digit)
      DIG_P1: o_addend = i_y_ext;
      DIG_P2: o_addend = {i_y_ext[EW-2:0], 1'b0};
      DIG_M1: begin
        o_addend = ~i_y_ext;
        o_cin    = 1'b1;
      end
      DIG_M2: begin
        o_addend = ~{i_y_ext[EW-2:0], 1'b0};
        o_cin    = 1'b1;
      end
      default: begin
        o_addend = '0;
        o_cin    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Multi-cycle radix-4 Booth multiplier (signed/unsigned) with a
// start/busy/done handshake and registered HI/LO product words.
module booth_mul_seq
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo
);

  localparam int N  = step_count(WIDTH);
  localparam int EW = WIDTH + 2;
  localparam int CW = $clog2(N + 1);

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [EW-1:0]   r_acc_hi;
  logic [EW-1:0]   r_acc_lo;
  logic            r_xm1;
  logic [EW-1:0]   r_y;
  logic [WIDTH-1:0] r_z_hi;
  logic [WIDTH-1:0] r_z_lo;

  logic [2:0]      w_triplet;
  logic [EW-1:0]   w_addend;
  logic            w_cin;
  logic [EW:0]     w_sum;
  logic [EW-1:0]   w_acc_hi_nx;
  logic [EW-1:0]   w_acc_lo_nx;
  logic            w_accept;

  assign w_triplet = {r_acc_lo[1:0], r_xm1};

  booth_r4_recode #(.EW(EW)) u_recode (
    .i_triplet (w_triplet),
    .i_y_ext   (r_y),
    .o_addend  (w_addend),
    .o_cin     (w_cin)
  );

  // One guard bit above the upper half: |acc + 2y| can exceed EW signed bits
  // before the shift, but never after it.
  assign w_sum = {r_acc_hi[EW-1], r_acc_hi}
               + {w_addend[EW-1], w_addend}
               + {{EW{1'b0}}, w_cin};

  assign w_acc_hi_nx = {w_sum[EW], w_sum[EW:2]};
  assign w_acc_lo_nx = {w_sum[1:0], r_acc_lo[EW-1:2]};

  assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_xm1    <= 1'b0;
      r_y      <= '0;
      r_z_hi   <= '0;
      r_z_lo   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_acc_hi <= '0;
            r_acc_lo <= {{2{signed_mode & x[WIDTH-1]}}, x};
            r_y      <= {{2{signed_mode & y[WIDTH-1]}}, y};
            r_xm1    <= 1'b0;
            r_cnt    <= CW'(N);
            r_state  <= ST_RUN;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_acc_hi <= w_acc_hi_nx;
          r_acc_lo <= w_acc_lo_nx;
          r_xm1    <= r_acc_lo[1];
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_z_hi  <= {w_acc_hi_nx[WIDTH-3:0], w_acc_lo_nx[WIDTH+1:WIDTH]};
            r_z_lo  <= w_acc_lo_nx[WIDTH-1:0];
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign z_hi = r_z_hi;
  assign z_lo = r_z_lo;

endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Parametrised, multi-cycle radix-4 Booth multiplier for the CPU datapath's MUL instruction. It supports both signed and unsigned operands and produces a 2×WIDTH-bit product split into HI and LO words for the HI/LO register pair. It sits beside the ALU and is controlled by the control unit through a start/busy/done handshake. It retires two multiplier bits per clock instead of iterating one bit at a time combinationally.

## Interface
- WIDTH, 32, operand width; must be even and ≥ 4.
- N (localparam), WIDTH/2+1, number of radix-4 iteration steps.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; **one clock; reset is synchronous and active-high**.
- start  in  1  request a multiply; sampled only when the unit can accept it (IDLE or DONE).
- signed_mode  in  1  1 = both operands two's complement; 0 = both unsigned; latched together with start.
- x  in  WIDTH  multiplier; latched together with start.
- y  in  WIDTH  multiplicand; latched together with start.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle pulse; the result is valid in that cycle.
- z_hi  out  WIDTH  product bits [2·WIDTH-1:WIDTH].
- z_lo  out  WIDTH  product bits [WIDTH-1:0].

## Operation
- States:
  - IDLE: reset state.
  - RUN: iteration in progress.
  - DONE: one cycle, then returns to IDLE.
- Accepting a request (start=1 in IDLE or DONE):
  - x and y are extended to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended if 0.
  - Accumulator is cleared, the appended bit x[-1] is cleared, the step counter is loaded with N, and the state moves to RUN.
- Each RUN cycle:
  - Recode the triplet {x[i+1], x[i], x[i-1]} to a digit in {-2,-1,0,+1,+2}.
  - Add digit·y to the upper half of the (2·WIDTH+4)-bit accumulator. Negation is done by ones-complement plus carry-in, never by a separate subtract.
  - Arithmetic-shift the accumulator right by 2.
  - Decrement the counter. When it reaches 0, go to DONE.
- DONE:
  - Register z_hi and z_lo from the low 2·WIDTH bits of the accumulator.
  - z_hi and z_lo then hold their value until the next DONE or until reset.
- start while in RUN is ignored: no restart and no queuing.
- Reset at any time, including mid-RUN: next state is IDLE, the partial result is discarded, and busy, done, z_hi and z_lo go to 0.
- Extension to WIDTH+2 bits makes unsigned operands with MSB=1 exact. No overflow is possible because the full product width is kept.

## Timing
- Reset values: busy=0, done=0, z_hi=0, z_lo=0, state=IDLE.
- Latency: start sampled at edge t. busy=1 for cycles t+1 … t+N. done=1 in cycle t+N+1. For WIDTH=32 that is done at cycle t+18.
- Throughput: start asserted in the DONE cycle is accepted. Back-to-back operations therefore issue every N+1 cycles.
- Changes to x, y and signed_mode after acceptance have no effect on the operation in flight.
- done and busy are never high in the same cycle.

## Structure
- Shared package booth_mul_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the Booth digit encoding (5-value enum: ZERO, P1, P2, M1, M2);
  - a function computing the step count from WIDTH.
- Sub-module booth_r4_recode: combinational. Maps the 3-bit triplet to the digit, and the digit plus the extended y to the partial-product addend and its carry-in. It is instantiated once.
- Everything else (FSM, counter, accumulator, output registers) stays in booth_mul_seq.

## Test plan
- Signed small: WIDTH=32, signed_mode=1, x=5, y=-3 → done at t+18; z_hi=FFFFFFFF, z_lo=FFFFFFF1.
- Mode distinction: x=y=FFFFFFFF.
  - signed_mode=0 → z_hi=FFFFFFFE, z_lo=00000001.
  - signed_mode=1 → z_hi=00000000, z_lo=00000001.
- Extremes, signed: x=y=80000000 → z_hi=40000000, z_lo=00000000. Also x=7FFFFFFF, y=80000000 → z_hi=C0000000, z_lo=80000000.
- Handshake:
  - Pulse start again at t+5 with different operands → ignored; the first result is unchanged at t+18.
  - Start in the DONE cycle → second done exactly 18 cycles later.
- Reset mid-op: assert rst at t+9 for one cycle → busy, done, z_hi and z_lo are 0 the next cycle. No done pulse follows. A fresh start then completes correctly.
- Parametrisation: WIDTH=8, exhaustive 256×256 operands in both modes against a reference model. Latency is 6 cycles (N=5).
